multicycle_core: RTL and testbench



---
 rtl/multicycle_core.sv | 168 ++++++++++++++++
 tb/tb_multicycle_core.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
// Multi-cycle core: FETCH/EXEC with handshaked fetch, input, output and a halt state.
// Datapath width and register count are parametrised; instruction word is fixed at 32 bits.
module multicycle_core #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 10,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   pc,
    output logic              halted
);
    localparam int RA_W = $clog2(NREG);

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_IN_WAIT, S_OUT_WAIT, S_HALT} state_t;

    state_t            state_q;
    logic [PC_W-1:0]   pc_q, npc_q;
    logic [31:0]       ir_q;
    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] out_data_q;
    logic              imem_req_q, in_ready_q, out_valid_q, halted_q;

    logic              j, b, we;
    logic [1:0]        src;
    logic [3:0]        aluop;
    logic [4:0]        a1, a2, a3;
    logic [7:0]        imm;

    logic [DATA_W-1:0] rd1, rd2, alu_d, wdata_d, se;
    logic [PC_W-1:0]   sep, npc_d;
    logic [4:0]        shamt;
    logic              flag_d, wr_ok, halt_d;

    assign {j, b, we, src, aluop, a1, a2, a3, imm} = ir_q;

    assign se     = DATA_W'($signed(imm));
    assign sep    = PC_W'($signed(imm));
    assign shamt  = rd2[4:0];
    assign wr_ok  = (a3 != 5'd0) && (int'(a3) < NREG);
    assign halt_d = j && (imm == 8'd0);

    // Register 0 and addresses beyond NREG read as zero.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (a1 != 5'd0 && int'(a1) < NREG) rd1 = rf_q[a1[RA_W-1:0]];
        if (a2 != 5'd0 && int'(a2) < NREG) rd2 = rf_q[a2[RA_W-1:0]];
    end

    always_comb begin
        alu_d  = '0;
        flag_d = 1'b0;
        case (aluop)
            4'b0000: alu_d = rd1 + rd2;
            4'b0001: alu_d = rd1 - rd2;
            4'b0010: alu_d = rd1 << shamt;
            4'b0011: alu_d = {{(DATA_W-1){1'b0}}, ($signed(rd1) < $signed(rd2))};
            4'b0100: alu_d = {{(DATA_W-1){1'b0}}, (rd1 < rd2)};
            4'b0101: alu_d = rd1 ^ rd2;
            4'b0110: alu_d = rd1 >> shamt;
            4'b0111: alu_d = $signed(rd1) >>> shamt;
            4'b1000: alu_d = rd1 | rd2;
            4'b1001: alu_d = rd1 & rd2;
            4'b1010: flag_d = rd1 < rd2;
            4'b1011: flag_d = rd1 >= rd2;
            4'b1100: flag_d = rd1 == rd2;
            4'b1101: flag_d = rd1 != rd2;
            4'b1110: flag_d = $signed(rd1) < $signed(rd2);
            4'b1111: flag_d = $signed(rd1) >= $signed(rd2);
        endcase
    end

    always_comb begin
        case (src)
            2'b00:   wdata_d = se;
            2'b01:   wdata_d = sw_data;
            default: wdata_d = alu_d;
        endcase
        npc_d = (j || (b && flag_d)) ? pc_q + sep : pc_q + PC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            npc_q       <= '0;
            ir_q        <= '0;
            out_data_q  <= '0;
            imem_req_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    // Request is raised one cycle after reset, then held until acked.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_ack) begin
                        ir_q       <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    npc_q <= npc_d;
                    if (halt_d) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else if (src == 2'b11 && we) begin
                        in_ready_q <= 1'b1;
                        state_q    <= S_IN_WAIT;
                    end else if (src == 2'b11) begin
                        out_data_q  <= rd1;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT_WAIT;
                    end else begin
                        if (we && wr_ok) rf_q[a3[RA_W-1:0]] <= wdata_d;
                        pc_q       <= npc_d;
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_IN_WAIT: begin
                    if (in_valid) begin
                        if (wr_ok) rf_q[a3[RA_W-1:0]] <= in_data;
                        in_ready_q <= 1'b0;
                        pc_q       <= npc_q;
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_OUT_WAIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        pc_q        <= npc_q;
                        imem_req_q  <= 1'b1;
                        state_q     <= S_FETCH;
                    end
                end
                S_HALT: begin
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: a 32-bit/32-reg core runs a directed program and a
// 16-bit/8-reg core covers narrow-width wrap, out-of-range registers and reset in IN_WAIT.
module tb_multicycle_core;
    logic        clk;
    int          checks = 0, errors = 0, cyc = 0;

    // 32-bit instance
    logic        a_reset, a_imem_req, a_imem_ack, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_halted;
    logic [9:0]  a_imem_addr, a_pc;
    logic [31:0] a_imem_rdata, a_sw, a_in_data, a_out_data;
    // 16-bit instance
    logic        b_reset, b_imem_req, b_imem_ack, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_halted;
    logic [9:0]  b_imem_addr, b_pc;
    logic [31:0] b_imem_rdata;
    logic [15:0] b_sw, b_in_data, b_out_data;

    logic [31:0] prog_a [1024];
    logic [31:0] prog_b [1024];
    logic [31:0] sb_a [$];
    logic [15:0] sb_b [$];
    int          ack_dly = 0, a_wcnt = 0, n_ack = 0;
    int          ack_cyc [64];
    logic [9:0]  ack_pc  [64];

    multicycle_core #(.DATA_W(32), .PC_W(10), .NREG(32)) dut_a (
        .clk(clk), .reset(a_reset), .imem_req(a_imem_req), .imem_addr(a_imem_addr),
        .imem_ack(a_imem_ack), .imem_rdata(a_imem_rdata), .sw_data(a_sw), .in_data(a_in_data),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .pc(a_pc), .halted(a_halted));

    multicycle_core #(.DATA_W(16), .PC_W(10), .NREG(8)) dut_b (
        .clk(clk), .reset(b_reset), .imem_req(b_imem_req), .imem_addr(b_imem_addr),
        .imem_ack(b_imem_ack), .imem_rdata(b_imem_rdata), .sw_data(b_sw), .in_data(b_in_data),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .pc(b_pc), .halted(b_halted));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ins(input logic j, input logic b, input logic we, input logic [1:0] src,
                                        input logic [3:0] op, input logic [4:0] r1, input logic [4:0] r2,
                                        input logic [4:0] rd, input logic [7:0] imm);
        return {j, b, we, src, op, r1, r2, rd, imm};
    endfunction
    function automatic logic [31:0] li(input logic [4:0] rd, input logic [7:0] imm);
        return ins(0, 0, 1, 2'b00, 4'h0, 5'd0, 5'd0, rd, imm);
    endfunction
    function automatic logic [31:0] outr(input logic [4:0] r1);
        return ins(0, 0, 0, 2'b11, 4'h0, r1, 5'd0, 5'd0, 8'h00);
    endfunction
    function automatic logic [31:0] alu(input logic [3:0] op, input logic [4:0] r1, input logic [4:0] r2,
                                        input logic [4:0] rd);
        return ins(0, 0, 1, 2'b10, op, r1, r2, rd, 8'h00);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits at negedges for a DUT-A condition; an expired budget is a failed check.
    task automatic wait_for(input int which, input string tag);
        logic c;
        for (int n = 0; n < 400; n++) begin
            c = (which == 0) ? a_in_ready : (which == 1) ? a_out_valid : a_halted;
            if (c) break;
            @(negedge clk);
        end
        c = (which == 0) ? a_in_ready : (which == 1) ? a_out_valid : a_halted;
        chk(tag, {31'd0, c}, 32'd1);
    endtask

    // Instruction memories: ack after ack_dly request cycles (B always same-cycle).
    initial begin
        a_imem_ack = 1'b0; a_imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (a_imem_req && a_wcnt >= ack_dly) begin
                a_imem_ack = 1'b1;
                a_imem_rdata = prog_a[a_imem_addr];
                if (n_ack < 64) begin
                    ack_cyc[n_ack] = cyc;
                    ack_pc[n_ack]  = a_imem_addr;
                end
                n_ack++;
                a_wcnt = 0;
            end else begin
                a_imem_ack = 1'b0;
                a_wcnt = a_imem_req ? a_wcnt + 1 : 0;
            end
        end
    end

    initial begin
        b_imem_ack = 1'b0; b_imem_rdata = '0;
        forever begin
            @(negedge clk);
            b_imem_ack = b_imem_req;
            b_imem_rdata = prog_b[b_imem_addr];
        end
    end

    // Output scoreboards: compare on each accepted transfer.
    initial forever begin
        logic [31:0] e;
        @(negedge clk);
        #1;
        if (a_out_valid && a_out_ready) begin
            e = (sb_a.size() != 0) ? sb_a.pop_front() : 'x;
            chk("a_out", a_out_data, e);
        end
        if (b_out_valid && b_out_ready) begin
            e = (sb_b.size() != 0) ? {16'h0, sb_b.pop_front()} : 'x;
            chk("b_out", {16'h0, b_out_data}, e);
        end
    end

    initial begin
        int hi;
        a_reset = 1'b1; b_reset = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1; a_sw = 32'hA5A5_0F0F;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1; b_sw = 16'h0;
        for (int i = 0; i < 1024; i++) begin prog_a[i] = '0; prog_b[i] = '0; end

        prog_a[0]    = li(2, 8'h05);
        prog_a[1]    = li(4, 8'h05);
        prog_a[2]    = ins(0, 1, 1, 2'b00, 4'hC, 5'd2, 5'd4, 5'd14, 8'hFD); // eq taken, writes r14
        prog_a[1023] = ins(1, 0, 0, 2'b00, 4'h0, 5'd0, 5'd0, 5'd0, 8'h05);   // jump wraps to 4
        prog_a[4]    = ins(0, 1, 0, 2'b00, 4'hD, 5'd2, 5'd4, 5'd0, 8'h10);   // ne not taken
        prog_a[5]    = li(1, 8'hFF);
        prog_a[6]    = outr(1);       sb_a.push_back(32'hFFFF_FFFF);
        prog_a[7]    = ins(0, 0, 1, 2'b01, 4'h0, 5'd0, 5'd0, 5'd6, 8'h00);
        prog_a[8]    = alu(4'h5, 6, 1, 7);
        prog_a[9]    = outr(7);       sb_a.push_back(32'h5A5A_F0F0);
        prog_a[10]   = alu(4'h0, 1, 2, 8);
        prog_a[11]   = outr(8);       sb_a.push_back(32'h0000_0004);
        prog_a[12]   = alu(4'h2, 2, 2, 9);
        prog_a[13]   = outr(9);       sb_a.push_back(32'h0000_00A0);
        prog_a[14]   = alu(4'h6, 1, 2, 10);
        prog_a[15]   = outr(10);      sb_a.push_back(32'h07FF_FFFF);
        prog_a[16]   = alu(4'h3, 1, 2, 11);
        prog_a[17]   = outr(11);      sb_a.push_back(32'h0000_0001);
        prog_a[18]   = alu(4'h1, 2, 1, 12);
        prog_a[19]   = outr(12);      sb_a.push_back(32'h0000_0006);
        prog_a[20]   = li(0, 8'h33);
        prog_a[21]   = outr(0);       sb_a.push_back(32'h0000_0000);
        prog_a[22]   = outr(14);      sb_a.push_back(32'hFFFF_FFFD);
        prog_a[23]   = ins(0, 0, 1, 2'b11, 4'h0, 5'd0, 5'd0, 5'd3, 8'h00);
        prog_a[24]   = li(13, 8'h07);
        prog_a[25]   = outr(3);       sb_a.push_back(32'h0000_1234);
        prog_a[26]   = ins(1, 0, 0, 2'b00, 4'h0, 5'd0, 5'd0, 5'd0, 8'h00);   // halt

        prog_b[0]  = li(9, 8'h55);
        prog_b[1]  = outr(9);         sb_b.push_back(16'h0000);
        prog_b[2]  = outr(1);         sb_b.push_back(16'h0000);
        prog_b[3]  = li(1, 8'hFF);
        prog_b[4]  = li(2, 8'h01);
        prog_b[5]  = alu(4'h0, 1, 2, 3);
        prog_b[6]  = outr(1);         sb_b.push_back(16'hFFFF);
        prog_b[7]  = outr(3);         sb_b.push_back(16'h0000);
        prog_b[8]  = li(7, 8'h12);
        prog_b[9]  = outr(7);         sb_b.push_back(16'h0012);
        prog_b[10] = ins(0, 0, 1, 2'b11, 4'h0, 5'd0, 5'd0, 5'd4, 8'h00);

        repeat (3) @(negedge clk);
        chk("rst_pc", {22'd0, a_pc}, 32'd0);
        chk("rst_req", {31'd0, a_imem_req}, 32'd0);
        chk("rst_in_ready", {31'd0, a_in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        chk("rst_halted", {31'd0, a_halted}, 32'd0);
        chk("rst_out_data", a_out_data, 32'd0);
        chk("b_rst_req", {31'd0, b_imem_req}, 32'd0);
        a_reset = 1'b0; b_reset = 1'b0;
        @(negedge clk);
        chk("req_first_cycle", {31'd0, a_imem_req}, 32'd1);

        // Input handshake: in_valid low for 4 cycles, then data in the 5th.
        wait_for(0, "wait_in_ready");
        a_out_ready = 1'b0;
        ack_dly = 3;
        chk("in_wait_pc", {22'd0, a_pc}, 32'd23);
        hi = a_in_ready ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a_in_ready) hi++;
        end
        a_in_valid = 1'b1; a_in_data = 32'h1234;
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("in_ready_cycles", hi, 32'd5);
        chk("in_ready_drop", {31'd0, a_in_ready}, 32'd0);

        // Output stall with out_ready low for 3 cycles.
        wait_for(1, "wait_out_valid");
        for (int i = 0; i < 3; i++) begin
            chk("out_hold_data", a_out_data, 32'h1234);
            chk("out_hold_pc", {22'd0, a_pc}, 32'd25);
            @(negedge clk);
        end
        chk("out_hold_valid", {31'd0, a_out_valid}, 32'd1);
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("out_valid_fall", {31'd0, a_out_valid}, 32'd0);
        chk("out_pc_adv", {22'd0, a_pc}, 32'd26);

        wait_for(2, "wait_halted");
        for (int i = 0; i < 4; i++) begin
            chk("halt_pc", {22'd0, a_pc}, 32'd26);
            chk("halt_req", {31'd0, a_imem_req}, 32'd0);
            @(negedge clk);
        end
        chk("halt_stays", {31'd0, a_halted}, 32'd1);
        a_reset = 1'b1;
        @(negedge clk);
        chk("halt_rst_pc", {22'd0, a_pc}, 32'd0);
        chk("halt_rst_halted", {31'd0, a_halted}, 32'd0);

        chk("gap_ack0", ack_cyc[1] - ack_cyc[0], 32'd2);
        chk("gap_ack3", ack_cyc[25] - ack_cyc[24], 32'd5);
        chk("br_taken_pc", {22'd0, ack_pc[3]}, 32'd1023);
        chk("jmp_wrap_pc", {22'd0, ack_pc[4]}, 32'd4);
        chk("br_not_taken_pc", {22'd0, ack_pc[5]}, 32'd5);
        chk("halt_fetch_pc", {22'd0, ack_pc[26]}, 32'd26);

        // Narrow core sits in IN_WAIT; reset there must drop in_ready next cycle.
        chk("b_in_wait", {31'd0, b_in_ready}, 32'd1);
        chk("b_in_wait_pc", {22'd0, b_pc}, 32'd10);
        b_reset = 1'b1;
        @(negedge clk);
        chk("b_rst_in_ready", {31'd0, b_in_ready}, 32'd0);
        chk("b_rst_pc", {22'd0, b_pc}, 32'd0);

        chk("a_sb_empty", sb_a.size(), 32'd0);
        chk("b_sb_empty", sb_b.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
